// File: rtl/dm_access_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : dm_access_arbiter_pkg
// Brief  : Arbiter state, read-owner encoding and access-direction constants
//          shared by the data-memory arbiter and stall_control.
// Rev    : 1.0
// ============================================================================
package dm_access_arbiter_pkg;

    typedef enum logic [0:0] {
        ARB_PIPE = 1'b0,
        ARB_DMA  = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        PIPE = 2'd1,
        DMA  = 2'd2
    } rd_owner_t;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

endpackage
`default_nettype wire

// File: rtl/dm_access_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : dm_access_arbiter_if
// Brief  : Pipeline, DMA and memory-side signals of the data-memory arbiter.
// Rev    : 1.0
// ============================================================================
interface dm_access_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              pipe_req;
    logic              pipe_rw;
    logic [ADDR_W-1:0] pipe_addr;
    logic [DATA_W-1:0] pipe_wdata;
    logic              pipe_stall;
    logic [DATA_W-1:0] pipe_rdata;
    logic              pipe_rvalid;

    logic              dma_req;
    logic              dma_lock;
    logic              dma_rw;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_gnt;
    logic [DATA_W-1:0] dma_rdata;
    logic              dma_rvalid;

    logic              mem_en;
    logic              mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  pipe_req, pipe_rw, pipe_addr, pipe_wdata,
        output pipe_stall, pipe_rdata, pipe_rvalid,
        input  dma_req, dma_lock, dma_rw, dma_addr, dma_wdata,
        output dma_gnt, dma_rdata, dma_rvalid,
        output mem_en, mem_rw, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Requesters and memory side
    modport master (
        output pipe_req, pipe_rw, pipe_addr, pipe_wdata,
        input  pipe_stall, pipe_rdata, pipe_rvalid,
        output dma_req, dma_lock, dma_rw, dma_addr, dma_wdata,
        input  dma_gnt, dma_rdata, dma_rvalid,
        input  mem_en, mem_rw, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface
`default_nettype wire

// File: rtl/dm_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module : dm_access_arbiter
// Brief  : Shares the single-port data memory between the MEM stage and a
//          DMA/debug port; pipeline-first with bounded DMA wait and DMA lock.
// Rev    : 1.0
// ============================================================================
module dm_access_arbiter
    import dm_access_arbiter_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    dm_access_arbiter_if.slave  bus
);

    localparam logic [3:0] c_wait_max  = 4'(MAX_WAIT);
    localparam logic [3:0] c_wait_last = 4'(MAX_WAIT - 1);

    arb_state_t        r_state_q,      w_state_d;
    logic [3:0]        r_wait_cnt_q,   w_wait_cnt_d;
    rd_owner_t         r_rd_owner_q,   w_rd_owner_d;
    logic [DATA_W-1:0] r_pipe_rdata_q, w_pipe_rdata_d;
    logic [DATA_W-1:0] r_dma_rdata_q,  w_dma_rdata_d;

    logic w_pipe_grant;
    logic w_dma_gnt;
    logic w_dma_denied;
    logic w_pipe_stall;
    logic w_pipe_rvalid;
    logic w_dma_rvalid;

    // Grants are forced low while reset is held so every output reads 0.
    always_comb begin
        w_pipe_grant = 1'b0;
        w_dma_gnt    = 1'b0;
        w_dma_denied = 1'b0;
        w_pipe_stall = 1'b0;
        if (!reset) begin
            case (r_state_q)
                ARB_PIPE: begin
                    w_pipe_grant = bus.pipe_req;
                    w_dma_gnt    = bus.dma_req & ~bus.pipe_req;
                    w_dma_denied = bus.dma_req &  bus.pipe_req;
                end
                ARB_DMA: begin
                    w_dma_gnt    = bus.dma_req;
                    w_pipe_stall = bus.pipe_req;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            ARB_PIPE: begin
                if ((w_dma_gnt && bus.dma_lock) ||
                    (w_dma_denied && (r_wait_cnt_q == c_wait_last)))
                    w_state_d = ARB_DMA;
            end
            ARB_DMA: begin
                if (!bus.dma_req || !bus.dma_lock)
                    w_state_d = ARB_PIPE;
            end
            default: w_state_d = ARB_PIPE;
        endcase
    end

    always_comb begin
        w_wait_cnt_d = r_wait_cnt_q;
        if (w_dma_gnt || !bus.dma_req)
            w_wait_cnt_d = 4'd0;
        else if (w_dma_denied && (r_wait_cnt_q < c_wait_max))
            w_wait_cnt_d = r_wait_cnt_q + 4'd1;
    end

    always_comb begin
        w_rd_owner_d = NONE;
        if (w_pipe_grant && (bus.pipe_rw == RW_READ))
            w_rd_owner_d = PIPE;
        else if (w_dma_gnt && (bus.dma_rw == RW_READ))
            w_rd_owner_d = DMA;
    end

    // Read data passes straight through in the response cycle and is held after.
    always_comb begin
        w_pipe_rvalid  = !reset && (r_rd_owner_q == PIPE);
        w_dma_rvalid   = !reset && (r_rd_owner_q == DMA);
        w_pipe_rdata_d = reset ? '0 : (w_pipe_rvalid ? bus.mem_rdata : r_pipe_rdata_q);
        w_dma_rdata_d  = reset ? '0 : (w_dma_rvalid  ? bus.mem_rdata : r_dma_rdata_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q      <= ARB_PIPE;
            r_wait_cnt_q   <= 4'd0;
            r_rd_owner_q   <= NONE;
            r_pipe_rdata_q <= '0;
            r_dma_rdata_q  <= '0;
        end else begin
            r_state_q      <= w_state_d;
            r_wait_cnt_q   <= w_wait_cnt_d;
            r_rd_owner_q   <= w_rd_owner_d;
            r_pipe_rdata_q <= w_pipe_rdata_d;
            r_dma_rdata_q  <= w_dma_rdata_d;
        end
    end

    always_comb begin
        bus.mem_en    = w_pipe_grant | w_dma_gnt;
        bus.mem_rw    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (w_pipe_grant) begin
            bus.mem_rw    = bus.pipe_rw;
            bus.mem_addr  = bus.pipe_addr;
            bus.mem_wdata = bus.pipe_wdata;
        end else if (w_dma_gnt) begin
            bus.mem_rw    = bus.dma_rw;
            bus.mem_addr  = bus.dma_addr;
            bus.mem_wdata = bus.dma_wdata;
        end
    end

    assign bus.pipe_stall  = w_pipe_stall;
    assign bus.pipe_rvalid = w_pipe_rvalid;
    assign bus.pipe_rdata  = w_pipe_rdata_d;
    assign bus.dma_gnt     = w_dma_gnt;
    assign bus.dma_rvalid  = w_dma_rvalid;
    assign bus.dma_rdata   = w_dma_rdata_d;

endmodule
`default_nettype wire

// File: tb/tb_dm_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_dm_access_arbiter
// Brief  : Directed and randomized bench for dm_access_arbiter against a
//          cycle-level ownership model.
// Rev    : 1.0
// ============================================================================
module tb_dm_access_arbiter;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int MW = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dm_access_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    dm_access_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_WAIT(MW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: who owns the memory, how long the DMA has been refused, which
    // side gets next cycle's read data, and each side's last delivered word.
    int          m_dma_owns = 0;
    int          m_refused  = 0;
    int          m_pending  = 0;   // 0 nobody, 1 pipeline, 2 DMA
    logic [15:0] m_prd = '0, m_drd = '0;
    int          m_lat  = 0;
    bit          m_last_dg = 0;

    task automatic step(input bit rst,
                        input bit preq, input bit prw, input logic [15:0] paddr, input logic [15:0] pwd,
                        input bit dreq, input bit dlock, input bit drw,
                        input logic [15:0] daddr, input logic [15:0] dwd,
                        input logic [15:0] mrd);
        bit pg, dg, st, prv, drv, men, mrw, refused_now, owns_next;
        logic [15:0] prd, drd, maddr, mwd;
        @(negedge clk);
        reset = rst;
        bus.pipe_req = preq; bus.pipe_rw = prw; bus.pipe_addr = paddr; bus.pipe_wdata = pwd;
        bus.dma_req = dreq;  bus.dma_lock = dlock; bus.dma_rw = drw;
        bus.dma_addr = daddr; bus.dma_wdata = dwd;
        bus.mem_rdata = mrd;
        #1;
        pg  = !rst && (m_dma_owns == 0) && preq;
        dg  = !rst && ((m_dma_owns != 0) ? dreq : (dreq && !preq));
        st  = !rst && (m_dma_owns != 0) && preq;
        prv = !rst && (m_pending == 1);
        drv = !rst && (m_pending == 2);
        prd = rst ? 16'h0 : (prv ? mrd : m_prd);
        drd = rst ? 16'h0 : (drv ? mrd : m_drd);
        men = pg || dg;
        mrw   = pg ? prw   : (dg ? drw   : 1'b0);
        maddr = pg ? paddr : (dg ? daddr : 16'h0);
        mwd   = pg ? pwd   : (dg ? dwd   : 16'h0);

        check_eq("pipe_stall",  bus.pipe_stall,  st);
        check_eq("pipe_rvalid", bus.pipe_rvalid, prv);
        check_eq("pipe_rdata",  bus.pipe_rdata,  prd);
        check_eq("dma_gnt",     bus.dma_gnt,     dg);
        check_eq("dma_rvalid",  bus.dma_rvalid,  drv);
        check_eq("dma_rdata",   bus.dma_rdata,   drd);
        check_eq("mem_en",      bus.mem_en,      men);
        check_eq("mem_rw",      bus.mem_rw,      mrw);
        check_eq("mem_addr",    bus.mem_addr,    maddr);
        check_eq("mem_wdata",   bus.mem_wdata,   mwd);

        // Starvation bound: a held request is served by cycle MAX_WAIT+1.
        if (rst || !dreq) m_lat = 0;
        else begin
            m_lat++;
            if (dg) begin
                check_eq("dma_latency_ok", (m_lat <= MW + 1), 1);
                m_lat = 0;
            end
        end

        if (rst) begin
            m_dma_owns = 0; m_refused = 0; m_pending = 0; m_prd = '0; m_drd = '0;
        end else begin
            m_prd = prd; m_drd = drd;
            m_pending = (pg && !prw) ? 1 : ((dg && !drw) ? 2 : 0);
            refused_now = (m_dma_owns == 0) && dreq && preq;
            if (m_dma_owns != 0) owns_next = dreq && dlock;
            else owns_next = (dg && dlock) || (refused_now && (m_refused == MW - 1));
            if (dg || !dreq) m_refused = 0;
            else if (refused_now && m_refused < MW) m_refused++;
            m_dma_owns = owns_next ? 1 : 0;
        end
        m_last_dg = dg;
    endtask

    task automatic idle(input logic [15:0] mrd);
        step(0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 16'h0, mrd);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 16'h0, 16'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.pipe_req = 0; bus.pipe_rw = 0; bus.pipe_addr = '0; bus.pipe_wdata = '0;
        bus.dma_req = 0; bus.dma_lock = 0; bus.dma_rw = 0; bus.dma_addr = '0; bus.dma_wdata = '0;
        bus.mem_rdata = '0;

        // Reset with every request raised, then pipeline-only read.
        repeat (2) step(1, 1, 1, 16'hFFFF, 16'hFFFF, 1, 1, 1, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        check_eq("rst_mem_en", bus.mem_en, 0);
        step(0, 1, 0, 16'h0010, 16'h0, 0, 0, 0, 16'h0, 16'h0, 16'h1234);
        check_eq("post_rst_mem_en", bus.mem_en, 1);
        check_eq("post_rst_stall",  bus.pipe_stall, 0);
        idle(16'hBEEF);
        check_eq("prd_valid",  bus.pipe_rvalid, 1);
        check_eq("prd_value",  bus.pipe_rdata, 16'hBEEF);
        check_eq("prd_no_dma", bus.dma_rvalid, 0);

        // Both requesting: DMA refused MAX_WAIT cycles, then forced once.
        do_reset();
        for (int i = 0; i < MW; i++) begin
            step(0, 1, 1, 16'h0020, 16'h0A0A, 1, 0, 1, 16'h0030, 16'h0B0B, 16'h0);
            check_eq("starve_denied", bus.dma_gnt, 0);
        end
        step(0, 1, 1, 16'h0020, 16'h0A0A, 1, 0, 1, 16'h0030, 16'h0B0B, 16'h0);
        check_eq("starve_forced_gnt",   bus.dma_gnt, 1);
        check_eq("starve_forced_stall", bus.pipe_stall, 1);
        step(0, 1, 1, 16'h0020, 16'h0A0A, 1, 0, 1, 16'h0030, 16'h0B0B, 16'h0);
        check_eq("starve_pipe_back", bus.dma_gnt, 0);
        check_eq("starve_pipe_addr", bus.mem_addr, 16'h0020);

        // Locked burst of three DMA writes with the pipeline requesting.
        do_reset();
        for (int i = 0; i < MW; i++)
            step(0, 1, 1, 16'h0040, 16'h0, 1, 1, 1, 16'h0100, 16'hD000, 16'h0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, 16'h0040, 16'h0, 1, (i < 2), 1, 16'(16'h0100 + i), 16'(16'hD000 + i), 16'h0);
            check_eq("burst_gnt",   bus.dma_gnt, 1);
            check_eq("burst_stall", bus.pipe_stall, 1);
            check_eq("burst_wdata", bus.mem_wdata, 16'(16'hD000 + i));
        end
        step(0, 1, 1, 16'h0040, 16'h0, 0, 0, 0, 16'h0, 16'h0, 16'h0);
        check_eq("burst_end_stall", bus.pipe_stall, 0);

        // DMA read followed by reset: response dropped.
        do_reset();
        step(0, 0, 0, 16'h0, 16'h0, 1, 1, 0, 16'h0200, 16'h0, 16'h0);
        step(1, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 16'h0, 16'hCAFE);
        check_eq("rst_drop_rvalid", bus.dma_rvalid, 0);
        idle(16'hCAFE);
        check_eq("rst_drop_rvalid2", bus.dma_rvalid, 0);
        step(0, 1, 1, 16'h0050, 16'h0, 1, 0, 1, 16'h0060, 16'h0, 16'h0);
        check_eq("rst_drop_pipe_wins", bus.dma_gnt, 0);

        // Alternating single-sided reads, no bubbles.
        for (int i = 0; i < 8; i++) begin
            if (i[0]) step(0, 0, 0, 16'h0, 16'h0, 1, 0, 0, 16'(16'h0300 + i), 16'h0, 16'(16'h5000 + i));
            else      step(0, 1, 0, 16'(16'h0400 + i), 16'h0, 0, 0, 0, 16'h0, 16'h0, 16'(16'h5000 + i));
            if (i > 0) begin
                check_eq("alt_prv", bus.pipe_rvalid, i[0]);
                check_eq("alt_drv", bus.dma_rvalid, !i[0]);
            end
        end

        // Randomized traffic; a DMA request is held stable until granted.
        begin
            bit hold = 0;
            bit drw_h = 0;
            logic [15:0] da_h = '0, dw_h = '0;
            for (int c = 0; c < 1500; c++) begin
                bit rst_r, preq_r, dreq_r;
                rst_r  = ($urandom_range(0, 59) == 0);
                preq_r = ($urandom_range(0, 99) < 60);
                if (hold) dreq_r = 1;
                else begin
                    dreq_r = ($urandom_range(0, 99) < 45);
                    drw_h  = 1'($urandom);
                    da_h   = 16'($urandom);
                    dw_h   = 16'($urandom);
                end
                step(rst_r, preq_r, 1'($urandom), 16'($urandom), 16'($urandom),
                     dreq_r, ($urandom_range(0, 99) < 40), drw_h, da_h, dw_h, 16'($urandom));
                hold = !rst_r && dreq_r && !m_last_dg;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
